// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response channels of the shared-ALU issue controller.
// The master side is the requesters, the ALU and the response consumer. The slave side is the controller.
interface alu_issue_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_NUM     = 11
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [OP_NUM-1:0]     req0_op;
    logic [DATA_WIDTH-1:0] req0_src1;
    logic [DATA_WIDTH-1:0] req0_src2;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [OP_NUM-1:0]     req1_op;
    logic [DATA_WIDTH-1:0] req1_src1;
    logic [DATA_WIDTH-1:0] req1_src2;

    logic [OP_NUM-1:0]     alu_op;
    logic [DATA_WIDTH-1:0] alu_src1;
    logic [DATA_WIDTH-1:0] alu_src2;
    logic [DATA_WIDTH-1:0] alu_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;

    modport master (
        output req0_valid, req0_op, req0_src1, req0_src2,
        output req1_valid, req1_op, req1_src1, req1_src2,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_src1, alu_src2,
        input  rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req0_valid, req0_op, req0_src1, req0_src2,
        input  req1_valid, req1_op, req1_src1, req1_src2,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_src1, alu_src2,
        output rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Round-robin issue front-end for the shared single-cycle ALU.
// Define ALU_ISSUE_MUL_EN to build in the iterative shift-add multiplier for op bit 7.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_NUM     = 11
) (
    input  logic            clk,
    input  logic            reset,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
`ifdef ALU_ISSUE_MUL_EN
        MUL  = 2'd2,
`endif
        RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  lastGrant_q, lastGrant_d;
    logic [OP_NUM-1:0]     op_q, op_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d;
    logic [DATA_WIDTH-1:0] src2_q, src2_d;
    logic                  rspId_q, rspId_d;
    logic [DATA_WIDTH-1:0] rspResult_q, rspResult_d;

`ifdef ALU_ISSUE_MUL_EN
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]      count_q, count_d;
`endif

    logic                  grant0, grant1;
    logic                  ready0, ready1;
    logic [OP_NUM-1:0]     selOp;
    logic [DATA_WIDTH-1:0] selSrc1, selSrc2;

    // On a tie the requester that did not win last time gets the grant.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | lastGrant_q);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~lastGrant_q);

    // Ready is gated by reset so that nothing handshakes while reset is held.
    assign ready0 = (state_q == IDLE) & ~reset & grant0;
    assign ready1 = (state_q == IDLE) & ~reset & grant1;

    assign selOp   = ready1 ? bus.req1_op   : bus.req0_op;
    assign selSrc1 = ready1 ? bus.req1_src1 : bus.req0_src1;
    assign selSrc2 = ready1 ? bus.req1_src2 : bus.req0_src2;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_op     = (state_q == EXEC) ? op_q : '0;
    assign bus.alu_src1   = src1_q;
    assign bus.alu_src2   = src2_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rspId_q;
    assign bus.rsp_result = rspResult_q;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        op_d        = op_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        rspId_d     = rspId_q;
        rspResult_d = rspResult_q;
`ifdef ALU_ISSUE_MUL_EN
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
`endif

        case (state_q)
            IDLE: begin
                if (ready0 | ready1) begin
                    op_d    = selOp;
                    src1_d  = selSrc1;
                    src2_d  = selSrc2;
                    rspId_d = ready1;
`ifdef ALU_ISSUE_MUL_EN
                    if (selOp[7]) begin
                        mcand_d     = selSrc1;
                        mplier_d    = selSrc2;
                        count_d     = '0;
                        rspResult_d = '0;
                        state_d     = MUL;
                    end else begin
                        state_d = EXEC;
                    end
`else
                    state_d = EXEC;
`endif
                end
            end

            EXEC: begin
                rspResult_d = bus.alu_result;
                state_d     = RESP;
            end

`ifdef ALU_ISSUE_MUL_EN
            // The response register doubles as the shift-add accumulator.
            MUL: begin
                if (mplier_q[0]) begin
                    rspResult_d = rspResult_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d = RESP;
                end
            end
`endif

            RESP: begin
                if (bus.rsp_ready) begin
                    lastGrant_d = rspId_q;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            op_q        <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            rspId_q     <= 1'b0;
            rspResult_q <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            op_q        <= op_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            rspId_q     <= rspId_d;
            rspResult_q <= rspResult_d;
        end
    end

`ifdef ALU_ISSUE_MUL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: randomized requests, a transaction-level reference model and an ALU model.
// The multiply expectations follow ALU_ISSUE_MUL_EN.
module tb_alu_issue_ctrl;

    localparam int DW = 32;
    localparam int ON = 11;
`ifdef ALU_ISSUE_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    typedef struct {
        logic [ON-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        logic          id;
        int            acceptCyc;
        int            lat;
        int            aluCyc;
    } Txn_t;

    logic clk;
    logic reset;

    alu_issue_ctrl_if #(.DATA_WIDTH(DW), .OP_NUM(ON)) bus ();

    alu_issue_ctrl #(.DATA_WIDTH(DW), .OP_NUM(ON)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            checks = 0;
    int            passes = 0;
    int            cyc = 0;
    Txn_t          sb[$];
    int            respCycles[$];
    bit            busy = 1'b0;
    bit            modelLast = 1'b1;
    bit            respActive = 1'b0;
    logic          heldId;
    logic [DW-1:0] heldRes;
    bit            rndActive;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The external single-cycle ALU. Bit 7 (mul) has no ALU path and yields 0.
    function automatic logic [DW-1:0] aluFn(input logic [ON-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (op[0]) return a & b;
        if (op[1]) return a | b;
        if (op[2]) return a + b;
        if (op[3]) return a - b;
        if (op[4]) return a ^ b;
        if (op[5]) return a << b[4:0];
        if (op[6]) return a >> b[4:0];
        if (op[7]) return '0;
        if (op[8]) return {31'b0, $signed(a) < $signed(b)};
        if (op[9]) return {31'b0, a < b};
        if (op[10]) return $unsigned($signed(a) >>> b[4:0]);
        return '0;
    endfunction

    assign bus.alu_result = aluFn(bus.alu_op, bus.alu_src1, bus.alu_src2);

    function automatic bit isMulPath(input logic [ON-1:0] op);
        return MulEn && op[7];
    endfunction

    function automatic logic [DW-1:0] refResult(input logic [ON-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (isMulPath(op)) return a * b;
        return aluFn(op, a, b);
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        else
            passes++;
    endtask

    task automatic failOne(input string name, input logic [DW-1:0] actual);
        checks++;
        $display("[TB] FAIL %s: got 0x%0h, expected none (cycle %0d)", name, actual, cyc);
    endtask

    function automatic Txn_t makeTxn(input logic id, input logic [ON-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        Txn_t t;
        t.op        = op;
        t.a         = a;
        t.b         = b;
        t.res       = refResult(op, a, b);
        t.id        = id;
        t.acceptCyc = cyc;
        t.lat       = isMulPath(op) ? DW + 1 : 2;
        t.aluCyc    = 0;
        return t;
    endfunction

    // Monitor: checks the arbitration model every cycle and scores ALU drive and responses.
    always @(negedge clk) begin
        bit exp0, exp1;
        cyc++;
        if (!reset) begin
            exp0 = !busy && bus.req0_valid && (!bus.req1_valid || modelLast);
            exp1 = !busy && bus.req1_valid && (!bus.req0_valid || !modelLast);
            checkOutput("req0_ready", bus.req0_ready, exp0);
            checkOutput("req1_ready", bus.req1_ready, exp1);

            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back(makeTxn(1'b0, bus.req0_op, bus.req0_src1, bus.req0_src2));
                busy = 1'b1;
            end else if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back(makeTxn(1'b1, bus.req1_op, bus.req1_src1, bus.req1_src2));
                busy = 1'b1;
            end

            if (bus.alu_op != '0) begin
                if (sb.size() == 0) begin
                    failOne("alu_op_without_txn", bus.alu_op);
                end else begin
                    checkOutput("alu_op", bus.alu_op, sb[0].op);
                    checkOutput("alu_src1", bus.alu_src1, sb[0].a);
                    checkOutput("alu_src2", bus.alu_src2, sb[0].b);
                    sb[0].aluCyc++;
                end
            end

            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    failOne("rsp_unexpected", bus.rsp_result);
                end else begin
                    if (!respActive) begin
                        checkOutput("rsp_latency", cyc - sb[0].acceptCyc, sb[0].lat);
                        checkOutput("rsp_id", bus.rsp_id, sb[0].id);
                        checkOutput("rsp_result", bus.rsp_result, sb[0].res);
                        checkOutput("alu_op_cycles", sb[0].aluCyc,
                                    (sb[0].op != '0 && !isMulPath(sb[0].op)) ? 1 : 0);
                        respActive = 1'b1;
                        heldId     = bus.rsp_id;
                        heldRes    = bus.rsp_result;
                    end else begin
                        checkOutput("rsp_id_stable", bus.rsp_id, heldId);
                        checkOutput("rsp_result_stable", bus.rsp_result, heldRes);
                    end
                    if (bus.rsp_ready) begin
                        modelLast  = sb[0].id;
                        void'(sb.pop_front());
                        busy       = 1'b0;
                        respActive = 1'b0;
                        respCycles.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int who, input logic [ON-1:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input int idle);
        bit accepted;
        int waitCyc;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        if (who == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_src1 = a; bus.req0_src2 = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_src1 = a; bus.req1_src2 = b;
        end
        accepted = 1'b0;
        waitCyc  = 0;
        while (!accepted && waitCyc < 400) begin
            @(negedge clk);
            accepted = (who == 0) ? bus.req0_ready : bus.req1_ready;
            waitCyc++;
        end
        if (!accepted) failOne(who == 0 ? "req0_accept_timeout" : "req1_accept_timeout", waitCyc);
        @(posedge clk);
        #1;
        if (who == 0) begin
            bus.req0_valid = 1'b0; bus.req0_op = ON'($urandom); bus.req0_src1 = $urandom; bus.req0_src2 = $urandom;
        end else begin
            bus.req1_valid = 1'b0; bus.req1_op = ON'($urandom); bus.req1_src1 = $urandom; bus.req1_src2 = $urandom;
        end
    endtask

    function automatic logic [ON-1:0] randOp();
        int k;
        k = $urandom_range(0, ON);
        if (k == ON) return '0;
        return ON'(1) << k;
    endfunction

    function automatic logic [DW-1:0] randData();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom_range(0, 15));
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    task automatic randomReqs(input int who, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(who, randOp(), randData(), randData(), $urandom_range(0, 3));
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) failOne("drain_timeout", sb.size());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_src1 = '0; bus.req0_src2 = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_src1 = '0; bus.req1_src2 = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("reset_rsp_id", bus.rsp_id, 1'b0);
        checkOutput("reset_rsp_result", bus.rsp_result, '0);
        checkOutput("reset_alu_op", bus.alu_op, '0);
        checkOutput("reset_alu_src1", bus.alu_src1, '0);
        checkOutput("reset_alu_src2", bus.alu_src2, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single add");
        applyStimulus(0, 11'h004, 32'd5, 32'd7, 1);
        waitIdle();

        $display("[TB] round-robin with both requesters valid");
        respCycles.delete();
        fork
            begin applyStimulus(0, 11'h004, 32'd1, 32'd2, 0); applyStimulus(0, 11'h008, 32'd9, 32'd4, 0); end
            begin applyStimulus(1, 11'h001, 32'hF0F0, 32'hFF00, 0); applyStimulus(1, 11'h010, 32'hAAAA, 32'h5555, 0); end
        join
        waitIdle();
        checkOutput("rr_response_count", respCycles.size(), 4);
        for (int i = 1; i < respCycles.size(); i++)
            checkOutput("rr_response_spacing", respCycles[i] - respCycles[i-1], 3);

        $display("[TB] back-pressure");
        bus.rsp_ready = 1'b0;
        fork
            applyStimulus(0, 11'h004, 32'h1234_0000, 32'h0000_5678, 0);
            applyStimulus(1, 11'h002, 32'h0F, 32'hF0, 2);
            begin
                int n;
                n = 0;
                while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
                if (!bus.rsp_valid) failOne("bp_rsp_timeout", n);
                repeat (10) @(negedge clk);
                @(posedge clk);
                #1;
                bus.rsp_ready = 1'b1;
            end
        join
        waitIdle();

        $display("[TB] multiply on requester 1");
        applyStimulus(1, 11'h080, 32'hFFFF_FFFF, 32'd3, 0);
        waitIdle();
        applyStimulus(0, 11'h080, 32'h0001_0003, 32'h0000_FFFF, 0);
        waitIdle();

        $display("[TB] randomized traffic");
        rndActive = 1'b1;
        fork
            begin
                fork
                    randomReqs(0, 40);
                    randomReqs(1, 40);
                join
                rndActive = 1'b0;
            end
            begin
                while (rndActive) begin
                    @(posedge clk);
                    #1;
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                end
                bus.rsp_ready = 1'b1;
            end
        join
        waitIdle();

        $display("[TB] reset in the middle of an operation");
        applyStimulus(0, MulEn ? 11'h080 : 11'h004, 32'hDEAD_BEEF, 32'h0000_0123, 0);
        repeat (MulEn ? 10 : 0) @(posedge clk);
        #3;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("midreset_req0_ready", bus.req0_ready, 1'b0);
        checkOutput("midreset_req1_ready", bus.req1_ready, 1'b0);
        checkOutput("midreset_alu_op", bus.alu_op, '0);
        checkOutput("midreset_alu_src1", bus.alu_src1, '0);
        sb.delete();
        busy       = 1'b0;
        respActive = 1'b0;
        modelLast  = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        respCycles.delete();
        fork
            applyStimulus(0, 11'h004, 32'd100, 32'd23, 0);
            applyStimulus(1, 11'h008, 32'd100, 32'd23, 0);
        join
        waitIdle();
        checkOutput("post_reset_responses", respCycles.size(), 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing and arbitration front-end for the shared single-cycle ALU. Two requesters (fetch/decode-side and a secondary agent) each present an ALU operation over a valid/ready channel. The block round-robin arbitrates between them, registers the winning operands, drives the ALU for one cycle, and returns the registered result with the requester ID on a valid/ready response channel. With the multiply feature compiled in, it also executes `op_mul` (bit 7) as a multi-cycle shift-add, because the ALU has no multiply path.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand and result width.
- `OP_NUM`, 11: width of the one-hot ALU op vector (bit 7 = mul).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request valid.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  OP_NUM  one-hot op.
- `req0_src1`, `req0_src2` / `req1_src1`, `req1_src2`  in  DATA_WIDTH  operands.
- `alu_op`  out  OP_NUM  op driven to the ALU.
- `alu_src1`, `alu_src2`  out  DATA_WIDTH  operands driven to the ALU.
- `alu_result`  in  DATA_WIDTH  combinational ALU result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that issued the op (0/1).
- `rsp_result`  out  DATA_WIDTH  result.

## Operation
- FSM states: IDLE, EXEC, MUL (feature only), RESP.
- IDLE:
  - Arbitrate among valid requesters.
  - If only one is valid, grant it.
  - If both are valid, grant the one not recorded in `last_grant`.
  - `reqN_ready = (state==IDLE) & grantN`. It is combinational and never asserted outside IDLE.
  - On handshake, latch op/src1/src2/id.
  - Next state is MUL if the feature is enabled and `op[7]` is set; otherwise EXEC.
- EXEC:
  - `alu_op` = latched op; `alu_src1`/`alu_src2` = latched operands.
  - Capture `alu_result` into `rsp_result`, then go to RESP.
- MUL:
  - Shift-add over `DATA_WIDTH` cycles; counter runs 0..DATA_WIDTH-1.
  - Each cycle: if multiplier LSB is 1, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1. All arithmetic is modulo 2^DATA_WIDTH.
  - Result = low DATA_WIDTH bits of `src1*src2`. After the last count, go to RESP.
  - `alu_op` stays 0 in this state.
- RESP:
  - `rsp_valid` = 1, with `rsp_id`/`rsp_result` held stable.
  - On `rsp_ready`: update `last_grant` to `rsp_id`, then go to IDLE.
  - Back-pressure holds the FSM in RESP indefinitely.
- `alu_op` = 0 in every state except EXEC. `alu_src1`/`alu_src2` always reflect the latched operands.
- Ops are passed through unmodified; zero or multi-hot ops are not checked.
- Reset values:
  - state = IDLE, `last_grant` = 1 (so req0 wins the first tie).
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0.
  - Operand registers = 0, `alu_op` = 0.
- Reset mid-operation: any in-flight op is dropped and no response is produced.

## Timing
- Non-mul op: handshake at edge T → EXEC during cycle T..T+1 → `rsp_valid` high after edge T+2. Minimum 3 cycles per op (IDLE, EXEC, RESP).
- Mul op (feature on): handshake at edge T → `rsp_valid` high after edge T+1+DATA_WIDTH (33 cycles for the default width).
- Response acceptance: `rsp_valid` falls on the edge following `rsp_valid & rsp_ready`. The next request can be accepted in the cycle after that, so there is no accept in the same cycle as a response.
- Request inputs are ignored when their ready is low. A requester may drop valid without penalty.
- `alu_result` is sampled only at the end of EXEC. The ALU path must close in one cycle.

## Configuration
- `ALU_ISSUE_MUL_EN` defined:
  - MUL state and the iterative multiplier are compiled in.
  - `op[7]` requests return the 32-bit product low half.
- Not defined:
  - No MUL state or multiplier logic.
  - `op[7]` ops take the EXEC path like any other op. The ALU yields 0 for mul, so `rsp_result` = 0 at EXEC latency.

## Test plan
- Single add: req0 op=bit2, src1=5, src2=7 → req0_ready for 1 cycle; rsp_valid 2 cycles after accept; rsp_id=0, rsp_result=12; `alu_op` nonzero only during EXEC.
- Round-robin: both valid continuously, rsp_ready=1 → grants in order 0,1,0,1; each pair of responses is spaced 3 cycles apart.
- Back-pressure: rsp_ready=0 for 10 cycles during RESP → rsp_valid, rsp_id and rsp_result stay stable, both req_ready stay 0; accept resumes 1 cycle after rsp_ready=1.
- Multiply (macro on): req1 op=bit7, src1=0xFFFF_FFFF, src2=3 → rsp_valid 33 cycles after accept; rsp_result=0xFFFF_FFFD, rsp_id=1.
- Multiply (macro off): same stimulus → rsp_result=0 at 2-cycle latency.
- Async reset mid-MUL: assert reset at count 10 → rsp_valid, req_ready and alu_op go 0 immediately; after release, req0 wins the first tie; no stale response is emitted.
